station_sequencer: RTL and testbench
====================================

STATION_SEQUENCER -- requirements
Module: station_sequencer

Interface
REQ-001 SHALL have parameter DEB_CYC, default 1_000_000, meaning consecutive cycles needed to qualify `stop` rise or fall (10 ms at 100 MHz).
REQ-002 SHALL have parameter SETTLE_CYC, default 50_000_000, meaning chassis settle time between qualified stop and arm enable.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 300_000_000, meaning the maximum cycles any servo enable may wait for its done.
REQ-004 SHALL have port `clk`, input, 1 bit: the single system clock; every flop is on its rising edge.
REQ-005 SHALL have port `rst`, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port `stop`, input, 1 bit: ultrasonic obstacle/station detect; asynchronous to the sequence and bouncy.
REQ-007 SHALL have port `marble`, input, 2 bits: moisture class; 0 means no drop is required.
REQ-008 SHALL have port `done_servo_arm`, input, 1 bit: the arm servo has completed its motion.
REQ-009 SHALL have port `done_servo_marble`, input, 1 bit: the marble servo has completed its drop.
REQ-010 SHALL have port `IPS_using_US`, output, 1 bit: 1 means the chassis follows the IPS line; 0 means the chassis is halted.
REQ-011 SHALL have port `enable_servo_arm`, output, 1 bit: request arm motion.
REQ-012 SHALL have port `enable_servo_marble`, output, 1 bit: request marble drop.
REQ-013 SHALL have port `fault`, output, 1 bit: a servo timeout occurred.
REQ-014 SHALL have port `state`, output, 3 bits: current state encoding, for SSD/debug.
REQ-015 SHALL have port `station_count`, output, 4 bits: number of completed stations.

Function
REQ-016 SHALL implement states DRIVE=0, DEBOUNCE=1, SETTLE=2, ARM=3, MARBLE=4, WAIT_CLEAR=5, FAULT=6; code 7 SHALL be unreachable and SHALL recover to DRIVE on the next cycle.
REQ-017 SHALL register all outputs, which SHALL change only on clk edges.
REQ-018 SHALL double-flop `stop` before any use; all stop timings below are measured at the synchronized signal, adding 2 cycles of latency.
REQ-019 SHALL move DRIVE->DEBOUNCE when synced stop=1, and hold IPS_using_US=1 in DRIVE and DEBOUNCE only.
REQ-020 SHALL, in DEBOUNCE, return to DRIVE and clear the counter if stop=0, and go to SETTLE once stop has been 1 for DEB_CYC consecutive cycles.
REQ-021 SHALL, in SETTLE, count SETTLE_CYC cycles, then go to ARM; stop changes SHALL be ignored in SETTLE.
REQ-022 SHALL assert enable_servo_arm for the whole ARM state; done_servo_arm SHALL be sampled only from the second ARM cycle onward, and a sampled 1 SHALL exit to MARBLE if marble!=0, else to WAIT_CLEAR.
REQ-023 SHALL latch `marble` on entry to ARM; later changes to `marble` SHALL not alter the current station.
REQ-024 SHALL handle MARBLE identically to ARM, using enable_servo_marble and done_servo_marble, and exit to WAIT_CLEAR.
REQ-025 SHALL drop each enable on the cycle after its done is sampled, and SHALL never have both enables high at the same time.
REQ-026 SHALL, in WAIT_CLEAR, require stop=0 for DEB_CYC consecutive cycles (any 1 restarts the count), then go to DRIVE and increment station_count, saturating at 15.
REQ-027 SHALL use a timeout counter that restarts on entry to ARM and to MARBLE; reaching TIMEOUT_CYC without done SHALL go to FAULT.
REQ-028 SHALL give done priority when done and timeout expiry occur in the same cycle.
REQ-029 SHALL, in FAULT, force fault=1, IPS_using_US=0 and both enables=0; only reset SHALL exit FAULT.
REQ-030 SHALL size all counters to ceil(log2(max parameter + 1)) bits, and SHALL not let any counter wrap.

Reset
REQ-031 SHALL, while rst=0, immediately force state=DRIVE, IPS_using_US=1, both enables=0, fault=0, station_count=0, and clear all counters and synchronizers.
REQ-032 SHALL apply the same reset values when rst is asserted mid-ARM or mid-MARBLE, dropping the enable without waiting for done.
REQ-033 SHALL begin normal operation on the first clk edge after rst deasserts.

Verification (DEB_CYC=4, SETTLE_CYC=8, TIMEOUT_CYC=20)
REQ-034 SHALL cover a nominal station: stop=1 held, marble=2, each done pulsed 3 cycles after its enable -> IPS_using_US falls 6 cycles after stop rises, arm enable rises 8 cycles later, then marble enable, then WAIT_CLEAR; stop=0 for 4 cycles -> DRIVE and station_count=1.
REQ-035 SHALL cover a bouncy stop: stop high 3 cycles, low, high 3 cycles -> stays in DRIVE/DEBOUNCE, never reaches SETTLE, IPS_using_US stays 1.
REQ-036 SHALL cover marble=0 -> ARM goes straight to WAIT_CLEAR and enable_servo_marble never asserts.
REQ-037 SHALL cover done_servo_arm never asserting -> FAULT 20 cycles after ARM entry with fault=1, enables=0, IPS_using_US=0, held until rst.
REQ-038 SHALL cover done_servo_marble rising on the cycle timeout expires -> WAIT_CLEAR with fault=0.
REQ-039 SHALL cover rst asserted in MARBLE and 16 stations completed -> all outputs at reset values immediately, and station_count saturates at 15.

Source files
------------

// File: rtl/station_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : station_sequencer
// Description : Per-station stop/drop sequencer for a line-following chassis.
//               Debounces the ultrasonic stop detect, halts the chassis, lets
//               it settle, runs the arm servo and optionally the marble servo,
//               waits for the station to clear, then resumes driving and
//               counts the station. Any servo that overruns its timeout
//               latches a fault that only reset clears.
// Revision    : 1.0 - initial release
// ============================================================================
module station_sequencer #(
  parameter int DEB_CYC     = 1_000_000,
  parameter int SETTLE_CYC  = 50_000_000,
  parameter int TIMEOUT_CYC = 300_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop,
  input  logic [1:0] marble,
  input  logic       done_servo_arm,
  input  logic       done_servo_marble,
  output logic       IPS_using_US,
  output logic       enable_servo_arm,
  output logic       enable_servo_marble,
  output logic       fault,
  output logic [2:0] state,
  output logic [3:0] station_count
);

  // Counter widths hold the largest value each counter is compared against.
  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  // Counters hold "samples seen so far minus one", so the terminal value is
  // the parameter minus one and no counter ever reaches its wrap point.
  localparam logic [DEB_W-1:0] c_deb_last    = DEB_W'(DEB_CYC - 1);
  localparam logic [SET_W-1:0] c_settle_last = SET_W'(SETTLE_CYC - 1);
  localparam logic [TMO_W-1:0] c_tmo_last    = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       c_count_max   = 4'd15;

  typedef enum logic [2:0] {
    S_DRIVE      = 3'd0,
    S_DEBOUNCE   = 3'd1,
    S_SETTLE     = 3'd2,
    S_ARM        = 3'd3,
    S_MARBLE     = 3'd4,
    S_WAIT_CLEAR = 3'd5,
    S_FAULT      = 3'd6
  } state_t;

  // Two-stage synchronizer for the asynchronous, bouncy stop detect.
  logic             stop_meta_q;
  logic             stop_sync_q;

  state_t           state_q,         state_d;
  logic [DEB_W-1:0] deb_cnt_q,       deb_cnt_d;
  logic [SET_W-1:0] settle_cnt_q,    settle_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q,       tmo_cnt_d;
  logic [1:0]       marble_q,        marble_d;
  logic [3:0]       station_count_q, station_count_d;
  logic             ips_q,           ips_d;
  logic             en_arm_q,        en_arm_d;
  logic             en_marble_q,     en_marble_d;
  logic             fault_q,         fault_d;

  // Next-state, counter and registered-output decode for the station sequence.
  always_comb begin
    state_d         = state_q;
    deb_cnt_d       = deb_cnt_q;
    settle_cnt_d    = settle_cnt_q;
    tmo_cnt_d       = tmo_cnt_q;
    marble_d        = marble_q;
    station_count_d = station_count_q;

    case (state_q)
      S_DRIVE: begin
        deb_cnt_d = '0;
        if (stop_sync_q) begin
          // The detecting cycle is the first of the qualifying run.
          state_d   = S_DEBOUNCE;
          deb_cnt_d = DEB_W'(1);
        end
      end

      S_DEBOUNCE: begin
        if (!stop_sync_q) begin
          state_d   = S_DRIVE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= c_deb_last) begin
          state_d      = S_SETTLE;
          deb_cnt_d    = '0;
          settle_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      S_SETTLE: begin
        // Stop is deliberately ignored while the chassis comes to rest.
        if (settle_cnt_q >= c_settle_last) begin
          state_d      = S_ARM;
          settle_cnt_d = '0;
          tmo_cnt_d    = '0;
          marble_d     = marble;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      S_ARM: begin
        // A zero timeout count marks the first ARM cycle, where done is
        // still stale from before the enable and must not be trusted.
        // Done is tested before expiry so a simultaneous done wins.
        if ((tmo_cnt_q != '0) && done_servo_arm) begin
          state_d   = (marble_q != 2'd0) ? S_MARBLE : S_WAIT_CLEAR;
          tmo_cnt_d = '0;
          deb_cnt_d = '0;
        end else if (tmo_cnt_q >= c_tmo_last) begin
          state_d   = S_FAULT;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      S_MARBLE: begin
        if ((tmo_cnt_q != '0) && done_servo_marble) begin
          state_d   = S_WAIT_CLEAR;
          tmo_cnt_d = '0;
          deb_cnt_d = '0;
        end else if (tmo_cnt_q >= c_tmo_last) begin
          state_d   = S_FAULT;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      S_WAIT_CLEAR: begin
        // Any detect restarts the clear run; the station only counts once
        // the obstacle has been gone for a full debounce window.
        if (stop_sync_q) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= c_deb_last) begin
          state_d   = S_DRIVE;
          deb_cnt_d = '0;
          if (station_count_q != c_count_max) begin
            station_count_d = station_count_q + 4'd1;
          end
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      S_FAULT: begin
        // Terminal until reset.
        state_d = S_FAULT;
      end

      default: begin
        // Unused encoding: fall back to driving with clean counters.
        state_d      = S_DRIVE;
        deb_cnt_d    = '0;
        settle_cnt_d = '0;
        tmo_cnt_d    = '0;
      end
    endcase

    // Outputs follow the state being entered so they are registered yet
    // aligned with the state register.
    ips_d       = (state_d == S_DRIVE) || (state_d == S_DEBOUNCE);
    en_arm_d    = (state_d == S_ARM);
    en_marble_d = (state_d == S_MARBLE);
    fault_d     = (state_d == S_FAULT);
  end

  // Register the synchronizer, sequence state, counters and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stop_meta_q     <= 1'b0;
      stop_sync_q     <= 1'b0;
      state_q         <= S_DRIVE;
      deb_cnt_q       <= '0;
      settle_cnt_q    <= '0;
      tmo_cnt_q       <= '0;
      marble_q        <= 2'd0;
      station_count_q <= 4'd0;
      ips_q           <= 1'b1;
      en_arm_q        <= 1'b0;
      en_marble_q     <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      stop_meta_q     <= stop;
      stop_sync_q     <= stop_meta_q;
      state_q         <= state_d;
      deb_cnt_q       <= deb_cnt_d;
      settle_cnt_q    <= settle_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      marble_q        <= marble_d;
      station_count_q <= station_count_d;
      ips_q           <= ips_d;
      en_arm_q        <= en_arm_d;
      en_marble_q     <= en_marble_d;
      fault_q         <= fault_d;
    end
  end

  assign IPS_using_US        = ips_q;
  assign enable_servo_arm    = en_arm_q;
  assign enable_servo_marble = en_marble_q;
  assign fault               = fault_q;
  assign state               = state_q;
  assign station_count       = station_count_q;

endmodule
`default_nettype wire

// File: tb/tb_station_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_station_sequencer
// Description : Self-checking bench for station_sequencer. A phase-level
//               reference model, driven by run lengths of the synchronized
//               stop detect and time spent in each phase, predicts every
//               output each cycle; directed scenarios are followed by a
//               randomized soak.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_station_sequencer;

  localparam int DEB = 4;
  localparam int SET = 8;
  localparam int TMO = 20;

  localparam int P_DRIVE  = 0;
  localparam int P_DEB    = 1;
  localparam int P_SETTLE = 2;
  localparam int P_ARM    = 3;
  localparam int P_MARBLE = 4;
  localparam int P_WAIT   = 5;
  localparam int P_FAULT  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stop = 1'b0;
  logic [1:0] marble = 2'd0;
  logic       done_servo_arm = 1'b0;
  logic       done_servo_marble = 1'b0;
  logic       IPS_using_US;
  logic       enable_servo_arm;
  logic       enable_servo_marble;
  logic       fault;
  logic [2:0] state;
  logic [3:0] station_count;

  station_sequencer #(
    .DEB_CYC    (DEB),
    .SETTLE_CYC (SET),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stop               (stop),
    .marble             (marble),
    .done_servo_arm     (done_servo_arm),
    .done_servo_marble  (done_servo_marble),
    .IPS_using_US       (IPS_using_US),
    .enable_servo_arm   (enable_servo_arm),
    .enable_servo_marble(enable_servo_marble),
    .fault              (fault),
    .state              (state),
    .station_count      (station_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: current phase, samples spent in it, station tally,
  // marble class captured for this station, and run lengths of the stop
  // detect as seen two cycles late.
  int         m_ph;
  int         m_t;
  int         m_cnt;
  logic [1:0] m_ml;
  int         ones_run;
  int         zeros_run;
  bit         pipe[$];

  // Stimulus control for the servo done responses.
  int arm_dly    = 3;
  int mrb_dly    = 3;
  bit pulse_mode = 1'b0;
  bit rnd_mode   = 1'b0;
  bit saw_settle = 1'b0;
  bit saw_mrb_en = 1'b0;
  bit saw_fault  = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    m_ph      = P_DRIVE;
    m_t       = 0;
    m_cnt     = 0;
    m_ml      = 2'd0;
    ones_run  = 0;
    zeros_run = 0;
    pipe      = {};
    pipe.push_back(1'b0);
    pipe.push_back(1'b0);
  endtask

  // One clock edge of the reference behaviour, using the inputs the DUT samples.
  task automatic model_step();
    bit s;
    int ti;
    int nxt;
    int zr;
    s = pipe.pop_front();
    pipe.push_back(stop);
    if (s) begin
      ones_run++;
      zeros_run = 0;
    end else begin
      zeros_run++;
      ones_run = 0;
    end
    ti  = m_t + 1;
    nxt = m_ph;
    case (m_ph)
      P_DRIVE:  if (s) nxt = P_DEB;
      P_DEB: begin
        if (!s) nxt = P_DRIVE;
        else if (ones_run >= DEB) nxt = P_SETTLE;
      end
      P_SETTLE: begin
        if (ti >= SET) begin
          nxt  = P_ARM;
          m_ml = marble;
        end
      end
      P_ARM: begin
        if (ti >= 2 && done_servo_arm) nxt = (m_ml != 2'd0) ? P_MARBLE : P_WAIT;
        else if (ti >= TMO) nxt = P_FAULT;
      end
      P_MARBLE: begin
        if (ti >= 2 && done_servo_marble) nxt = P_WAIT;
        else if (ti >= TMO) nxt = P_FAULT;
      end
      P_WAIT: begin
        zr = (zeros_run < ti) ? zeros_run : ti;
        if (zr >= DEB) begin
          nxt = P_DRIVE;
          if (m_cnt < 15) m_cnt++;
        end
      end
      default: ;
    endcase
    m_t  = (nxt != m_ph) ? 0 : ti;
    m_ph = nxt;
  endtask

  task automatic cmp_outputs(input string where);
    chk_eq({where, ".state"},      state,               m_ph);
    chk_eq({where, ".ips"},        IPS_using_US,        (m_ph == P_DRIVE) || (m_ph == P_DEB));
    chk_eq({where, ".en_arm"},     enable_servo_arm,    m_ph == P_ARM);
    chk_eq({where, ".en_marble"},  enable_servo_marble, m_ph == P_MARBLE);
    chk_eq({where, ".fault"},      fault,               m_ph == P_FAULT);
    chk_eq({where, ".count"},      station_count,       m_cnt);
  endtask

  function automatic bit dly_hit(input int smp, input int dly);
    return pulse_mode ? (smp == dly) : (smp >= dly);
  endfunction

  // Apply one clock: drive the dones, step the model, compare after the edge.
  task automatic cycle();
    bit na;
    bit nm;
    na = rnd_mode && ($urandom_range(3) == 0);
    nm = rnd_mode && ($urandom_range(3) == 0);
    done_servo_arm    = (m_ph == P_ARM)    ? dly_hit(m_t + 1, arm_dly) : na;
    done_servo_marble = (m_ph == P_MARBLE) ? dly_hit(m_t + 1, mrb_dly) : nm;
    @(posedge clk);
    if (rst) model_step();
    #1;
    cmp_outputs("cyc");
    saw_settle = saw_settle | (state == 3'd2);
    saw_mrb_en = saw_mrb_en | (enable_servo_marble == 1'b1);
    saw_fault  = saw_fault | (fault == 1'b1);
    if (rnd_mode && m_t == 0) begin
      if (m_ph == P_ARM) begin
        arm_dly    = int'($urandom_range(1, 24));
        pulse_mode = 1'($urandom_range(1));
      end
      if (m_ph == P_MARBLE) mrb_dly = int'($urandom_range(1, 24));
    end
    @(negedge clk);
  endtask

  // Assert reset mid-cycle; outputs must take reset values without a clock.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    cmp_outputs("rst");
    @(posedge clk);
    #1;
    cmp_outputs("rst_hold");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until_state(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (state !== 3'(target) && k < budget) begin
      cycle();
      k++;
    end
    chk_eq(tag, state, target);
  endtask

  task automatic station(input logic [1:0] mv, input int ad, input int md, input bit pm);
    marble     = mv;
    arm_dly    = ad;
    mrb_dly    = md;
    pulse_mode = pm;
    stop       = 1'b1;
    run_until_state(P_WAIT, 80, "reach_wait_clear");
    stop = 1'b0;
    run_until_state(P_DRIVE, 20, "back_to_drive");
  endtask

  initial begin
    int lat;
    int run_left;

    @(negedge clk);
    do_reset();

    // Nominal station with marble class 2 and 3-cycle done pulses.
    marble = 2'd2; arm_dly = 3; mrb_dly = 3; pulse_mode = 1'b1;
    stop = 1'b1;
    lat = 0;
    while (IPS_using_US === 1'b1 && lat < 40) begin cycle(); lat++; end
    chk_eq("ips_fall_latency", lat, 6);
    lat = 0;
    while (enable_servo_arm !== 1'b1 && lat < 40) begin cycle(); lat++; end
    chk_eq("arm_enable_latency", lat, 8);
    lat = 0;
    while (enable_servo_marble !== 1'b1 && lat < 40) begin cycle(); lat++; end
    chk_eq("marble_enable_seen", enable_servo_marble, 1);
    run_until_state(P_WAIT, 40, "nominal_wait_clear");
    stop = 1'b0;
    lat = 0;
    while (state !== 3'd0 && lat < 40) begin cycle(); lat++; end
    chk_eq("clear_latency", lat, 6);
    chk_eq("count_after_first", station_count, 1);

    // Bouncy detect never qualifies.
    saw_settle = 1'b0;
    stop = 1'b1; repeat (3) cycle();
    stop = 1'b0; cycle();
    stop = 1'b1; repeat (3) cycle();
    stop = 1'b0; repeat (8) cycle();
    chk_eq("bounce_no_settle", saw_settle, 0);
    chk_eq("bounce_ips_high", IPS_using_US, 1);

    // No marble required: marble enable must stay low.
    saw_mrb_en = 1'b0;
    station(2'd0, 4, 4, 1'b0);
    chk_eq("no_marble_enable", saw_mrb_en, 0);

    // Marble done arriving exactly at timeout expiry wins over the fault.
    saw_fault = 1'b0;
    station(2'd3, 3, TMO, 1'b0);
    chk_eq("tie_no_fault", saw_fault, 0);

    // Arm servo never answers: fault after the full timeout, held until reset.
    marble = 2'd1; arm_dly = 1000; pulse_mode = 1'b0;
    stop = 1'b1;
    lat = 0;
    while (enable_servo_arm !== 1'b1 && lat < 40) begin cycle(); lat++; end
    lat = 0;
    while (fault !== 1'b1 && lat < 60) begin cycle(); lat++; end
    chk_eq("arm_timeout_cycles", lat, TMO);
    for (int i = 0; i < 15; i++) begin
      stop = 1'($urandom_range(1));
      cycle();
    end
    chk_eq("fault_held", fault, 1);
    do_reset();

    // Reset in the middle of a marble drop.
    marble = 2'd1; arm_dly = 2; mrb_dly = 1000; pulse_mode = 1'b0;
    stop = 1'b1;
    run_until_state(P_MARBLE, 60, "reach_marble");
    repeat (4) cycle();
    do_reset();
    stop = 1'b0;

    // Sixteen stations: the tally saturates at 15.
    for (int i = 0; i < 16; i++) begin
      station(2'($urandom_range(0, 3)), int'($urandom_range(2, 6)),
              int'($urandom_range(2, 6)), 1'b0);
    end
    chk_eq("count_saturated", station_count, 15);

    // Randomized soak.
    do_reset();
    rnd_mode = 1'b1;
    run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        stop     = ~stop;
        run_left = int'($urandom_range(1, 14));
      end
      run_left--;
      if ($urandom_range(7) == 0) marble = 2'($urandom_range(0, 3));
      if ((m_ph == P_FAULT && m_t > 8) || $urandom_range(999) == 0) do_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
